// File: rtl/gelato_warp_scheduler.sv
// gelato_warp_scheduler: per-warp lifecycle/PC tracking with round-robin pick into a registered fetch slot
module gelato_warp_scheduler #(
  parameter int NUM_WARPS      = 32,
  parameter int WARP_NUM_WIDTH = $clog2(NUM_WARPS),
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      launch_valid,
  input  logic [WARP_NUM_WIDTH-1:0] launch_warp,
  input  logic [ADDR_WIDTH-1:0]     launch_pc,
  input  logic                      wb_valid,
  input  logic [WARP_NUM_WIDTH-1:0] wb_warp,
  input  logic [ADDR_WIDTH-1:0]     wb_pc,
  input  logic                      wb_exit,
  output logic                      fetch_valid,
  output logic [WARP_NUM_WIDTH-1:0] fetch_warp,
  output logic [ADDR_WIDTH-1:0]     fetch_pc,
  input  logic                      fetch_ready,
  output logic [NUM_WARPS-1:0]      active_mask,
  output logic                      all_idle
);
  typedef enum logic [1:0] {IDLE, READY, QUEUED, INFLIGHT} wstate_t;
  wstate_t                   st     [NUM_WARPS];
  wstate_t                   st_nxt [NUM_WARPS];
  logic [ADDR_WIDTH-1:0]     pc     [NUM_WARPS];
  logic [ADDR_WIDTH-1:0]     pc_nxt [NUM_WARPS];
  logic [WARP_NUM_WIDTH-1:0] rr_ptr, win, idx;
  logic                      found, load, accept;
  assign accept   = fetch_valid && fetch_ready;
  assign load     = (!fetch_valid || fetch_ready) && found;
  assign all_idle = ~|active_mask && !fetch_valid;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = rr_ptr + WARP_NUM_WIDTH'(k);
      if (!found && st[idx] == READY) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  // Every transition has a distinct source state, so at most one branch can fire per warp.
  always_comb begin
    active_mask = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      st_nxt[i]      = st[i];
      pc_nxt[i]      = pc[i];
      active_mask[i] = st[i] != IDLE;
      if (st[i] == IDLE && launch_valid && launch_warp == WARP_NUM_WIDTH'(i)) begin
        st_nxt[i] = READY;
        pc_nxt[i] = launch_pc;
      end else if (st[i] == READY && load && win == WARP_NUM_WIDTH'(i)) begin
        st_nxt[i] = QUEUED;
      end else if (st[i] == QUEUED && accept && fetch_warp == WARP_NUM_WIDTH'(i)) begin
        st_nxt[i] = INFLIGHT;
      end else if (st[i] == INFLIGHT && wb_valid && wb_warp == WARP_NUM_WIDTH'(i)) begin
        st_nxt[i] = wb_exit ? IDLE : READY;
        pc_nxt[i] = wb_exit ? pc[i] : wb_pc;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        st[i] <= IDLE;
        pc[i] <= '0;
      end
      rr_ptr      <= '0;
      fetch_valid <= 1'b0;
      fetch_warp  <= '0;
      fetch_pc    <= '0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        st[i] <= st_nxt[i];
        pc[i] <= pc_nxt[i];
      end
      if (load) begin
        rr_ptr      <= win + WARP_NUM_WIDTH'(1);
        fetch_valid <= 1'b1;
        fetch_warp  <= win;
        fetch_pc    <= pc[win];
      end else if (accept) begin
        fetch_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// tb_gelato_warp_scheduler: directed stimulus with a fetch scoreboard checked on every accepted slot
module tb_gelato_warp_scheduler;
  localparam int NW = 32, WW = 5, AW = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic launch_valid, wb_valid, wb_exit, fetch_valid, fetch_ready, all_idle;
  logic [WW-1:0] launch_warp, wb_warp, fetch_warp;
  logic [AW-1:0] launch_pc, wb_pc, fetch_pc;
  logic [NW-1:0] active_mask;
  typedef struct {logic [WW-1:0] w; logic [AW-1:0] pc;} fetch_t;
  fetch_t exp_q[$];
  int tests = 0, fails = 0;

  gelato_warp_scheduler #(.NUM_WARPS(NW), .WARP_NUM_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .launch_valid(launch_valid), .launch_warp(launch_warp), .launch_pc(launch_pc),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_pc(wb_pc), .wb_exit(wb_exit),
    .fetch_valid(fetch_valid), .fetch_warp(fetch_warp), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .active_mask(active_mask), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w, input logic [AW-1:0] p);
    fetch_t e;
    e.w = WW'(w);
    e.pc = p;
    exp_q.push_back(e);
  endtask

  task automatic launch(input int w, input logic [AW-1:0] p);
    launch_valid = 1'b1;
    launch_warp = WW'(w);
    launch_pc = p;
    tick();
    launch_valid = 1'b0;
  endtask

  task automatic wb(input int w, input logic [AW-1:0] p, input logic ex);
    wb_valid = 1'b1;
    wb_warp = WW'(w);
    wb_pc = p;
    wb_exit = ex;
    tick();
    wb_valid = 1'b0;
    wb_exit = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && fetch_valid && fetch_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_fetch: got warp %0d pc 0x%0h, required no fetch", fetch_warp, fetch_pc);
      end else begin
        fetch_t e;
        e = exp_q.pop_front();
        chk("sb_warp", 32'(fetch_warp), 32'(e.w));
        chk("sb_pc", fetch_pc, e.pc);
      end
    end
  end

  initial begin
    launch_valid = 1'b0; launch_warp = '0; launch_pc = '0;
    wb_valid = 1'b0; wb_warp = '0; wb_pc = '0; wb_exit = 1'b0;
    fetch_ready = 1'b1;
    #2;
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_fetch_warp", 32'(fetch_warp), 0);
    chk("rst_fetch_pc", fetch_pc, 0);
    chk("rst_active_mask", active_mask, 0);
    chk("rst_all_idle", 32'(all_idle), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // single launch: slot shows up two edges after the launch
    push(3, 32'h100);
    launch(3, 32'h100);
    chk("t1_slot_not_yet", 32'(fetch_valid), 0);
    tick();
    chk("t1_fetch_valid", 32'(fetch_valid), 1);
    chk("t1_fetch_warp", 32'(fetch_warp), 3);
    chk("t1_fetch_pc", fetch_pc, 32'h100);
    tick();
    chk("t1_active_mask", active_mask, 32'h8);
    chk("t1_slot_empty", 32'(fetch_valid), 0);
    wb(3, 32'h0, 1'b1);
    chk("t1_all_idle", 32'(all_idle), 1);
    // round robin over 0,1,2 then writeback round with pc+4
    push(0, 32'h10); push(1, 32'h20); push(2, 32'h30);
    launch(0, 32'h10); launch(1, 32'h20); launch(2, 32'h30);
    repeat (3) tick();
    chk("t2_active_mask", active_mask, 32'h7);
    push(0, 32'h14); push(1, 32'h24); push(2, 32'h34);
    wb(0, 32'h14, 1'b0); wb(1, 32'h24, 1'b0); wb(2, 32'h34, 1'b0);
    repeat (3) tick();
    wb(0, 32'h0, 1'b1); wb(1, 32'h0, 1'b1);
    chk("t2_mask_w2_only", active_mask, 32'h4);
    chk("t2_not_idle", 32'(all_idle), 0);
    wb(2, 32'h0, 1'b1);
    chk("t2_all_idle", 32'(all_idle), 1);
    chk("t2_mask_zero", active_mask, 0);
    // back-pressure hold
    fetch_ready = 1'b0;
    push(5, 32'h500); push(6, 32'h600);
    launch(5, 32'h500); launch(6, 32'h600);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", 32'(fetch_valid), 1);
      chk("t3_hold_warp", 32'(fetch_warp), 5);
      chk("t3_hold_pc", fetch_pc, 32'h500);
    end
    fetch_ready = 1'b1;
    tick();
    chk("t3_next_warp", 32'(fetch_warp), 6);
    chk("t3_next_pc", fetch_pc, 32'h600);
    tick();
    wb(5, 32'h0, 1'b1); wb(6, 32'h0, 1'b1);
    chk("t3_all_idle", 32'(all_idle), 1);
    // ignored launch/writebacks
    fetch_ready = 1'b0;
    push(7, 32'h700);
    launch(7, 32'h700);
    launch(7, 32'h200);
    wb(9, 32'h900, 1'b0);
    wb(7, 32'h300, 1'b0);
    chk("t4_active_mask", active_mask, 32'h80);
    chk("t4_fetch_warp", 32'(fetch_warp), 7);
    chk("t4_fetch_pc", fetch_pc, 32'h700);
    fetch_ready = 1'b1;
    tick();
    chk("t4_slot_empty", 32'(fetch_valid), 0);
    chk("t4_mask_after", active_mask, 32'h80);
    push(7, 32'h704);
    wb(7, 32'h704, 1'b0);
    repeat (2) tick();
    wb(7, 32'h0, 1'b1);
    chk("t4_all_idle", 32'(all_idle), 1);
    // asynchronous reset with a pending slot
    fetch_ready = 1'b0;
    launch(10, 32'ha00); launch(11, 32'hb00); launch(12, 32'hc00); launch(13, 32'hd00);
    chk("t5_pre_valid", 32'(fetch_valid), 1);
    chk("t5_pre_warp", 32'(fetch_warp), 10);
    chk("t5_pre_mask", active_mask, 32'h3c00);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(fetch_valid), 0);
    chk("t5_rst_mask", active_mask, 0);
    chk("t5_rst_all_idle", 32'(all_idle), 1);
    chk("t5_rst_warp", 32'(fetch_warp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
